// File: rtl/prg_loader.sv
// PRG download sequencer: parses the load-address header, streams the
// payload into main RAM, then writes the BASIC end-of-program pointers.
module prg_loader #(
  parameter logic [7:0] PRG_INDEX = 8'd1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        ram_wr,
  input  logic        ram_ack,
  output logic        busy,
  output logic        done,
  output logic [15:0] end_addr,
  output logic        overflow
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    DATA,
    PTR,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic        stb;
  logic        off0;
  logic        off1;
  logic [7:0]  load_lo;
  logic [15:0] wptr;
  logic        drain;
  logic [2:0]  pidx;

  logic [15:0] fa [2];
  logic [7:0]  fd [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  cnt;
  logic        full;
  logic        empty;

  logic        push;
  logic        pop;
  logic        drop;
  logic        hdr_lo;
  logic        hdr_hi;
  logic        to_ptr;
  logic        ptr_ack;

  logic [15:0] ptr_addr;
  logic [7:0]  ptr_data;

  assign stb   = ioctl_download & ioctl_wr
               & (ioctl_index == PRG_INDEX);
  assign off0  = (ioctl_addr == 25'd0);
  assign off1  = (ioctl_addr == 25'd1);
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    drop     = 1'b0;
    pop      = 1'b0;
    hdr_lo   = 1'b0;
    hdr_hi   = 1'b0;
    to_ptr   = 1'b0;
    ptr_ack  = 1'b0;
    unique case (state)
      IDLE: begin
        if (stb && off0) begin
          hdr_lo   = 1'b1;
          state_nx = HDR_HI;
        end
      end
      HDR_HI: begin
        if (!ioctl_download) begin
          state_nx = IDLE;
        end else if (stb && off1) begin
          hdr_hi   = 1'b1;
          state_nx = DATA;
        end
      end
      DATA: begin
        // once the download has ended, late strobes are no longer payload
        if (stb && !drain && !off0 && !off1) begin
          if (full) drop = 1'b1;
          else      push = 1'b1;
        end
        pop = ram_ack & ~empty;
        if ((drain || !ioctl_download) && empty) begin
          to_ptr   = 1'b1;
          state_nx = PTR;
        end
      end
      PTR: begin
        ptr_ack = ram_ack;
        if (ram_ack && pidx == 3'd7) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      load_lo  <= 8'd0;
      wptr     <= 16'd0;
      drain    <= 1'b0;
      pidx     <= 3'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      cnt      <= 2'd0;
      end_addr <= 16'd0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (hdr_lo) begin
        load_lo  <= ioctl_dout;
        overflow <= 1'b0;
      end
      if (hdr_hi) begin
        wptr  <= {ioctl_dout, load_lo};
        drain <= 1'b0;
      end
      if (state == DATA && !ioctl_download) drain <= 1'b1;
      if (push) begin
        wr_ptr <= ~wr_ptr;
        wptr   <= wptr + 16'd1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (push && !pop) cnt <= cnt + 2'd1;
      if (pop && !push) cnt <= cnt - 2'd1;
      if (drop) overflow <= 1'b1;
      if (to_ptr) begin
        end_addr <= wptr;
        pidx     <= 3'd0;
      end
      if (ptr_ack) pidx <= pidx + 3'd1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      fa[wr_ptr] <= wptr;
      fd[wr_ptr] <= ioctl_dout;
    end
  end

  // even slots carry the low byte, odd slots the high byte
  always_comb begin
    ptr_addr = 16'h0000;
    unique case (pidx)
      3'd0:    ptr_addr = 16'h002D;
      3'd1:    ptr_addr = 16'h002E;
      3'd2:    ptr_addr = 16'h002F;
      3'd3:    ptr_addr = 16'h0030;
      3'd4:    ptr_addr = 16'h0031;
      3'd5:    ptr_addr = 16'h0032;
      3'd6:    ptr_addr = 16'h00AE;
      3'd7:    ptr_addr = 16'h00AF;
      default: ptr_addr = 16'h0000;
    endcase
    ptr_data = pidx[0] ? end_addr[15:8] : end_addr[7:0];
  end

  always_comb begin
    ram_wr   = 1'b0;
    ram_addr = 16'd0;
    ram_data = 8'd0;
    if (state == PTR) begin
      ram_wr   = 1'b1;
      ram_addr = ptr_addr;
      ram_data = ptr_data;
    end else if (!empty) begin
      ram_wr   = 1'b1;
      ram_addr = fa[rd_ptr];
      ram_data = fd[rd_ptr];
    end
  end

  assign ioctl_wait = full | (state == PTR) | (state == DONE);
  assign busy       = (state == HDR_HI) | (state == DATA)
                    | (state == PTR);
  assign done       = (state == DONE);

endmodule
